// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus uart_tx handshake shared by the
// arbiter (master view) and its surroundings (slave view).
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_parity;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;

    // uart_tx side
    logic                 send_request;
    logic [7:0]           tx_data;
    logic                 parity_enable;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        input  req, req_data, req_parity, tx_busy, tx_done,
        output ack, done, grant_valid, grant_idx, send_request, tx_data, parity_enable
    );

    modport slave (
        output req, req_data, req_parity, tx_busy, tx_done,
        input  ack, done, grant_valid, grant_idx, send_request, tx_data, parity_enable
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte
// producers. The winner's byte and parity choice are latched at grant and
// held until the transmitter is released.
// Optional feature: define UART_TX_ARB_LOCK_EN to add the lock input, which
// lets a locked requester send up to LOCK_MAX bytes without re-arbitration.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic               clk,
    input  logic               resetn,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    uart_tx_arbiter_if.master  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1) begin : g_bad_params
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and LOCK_MAX >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t             state_q, state_nxt;
    logic [IDX_W-1:0]   rr_q, rr_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic               gv_q, gv_nxt;
    logic [7:0]         data_q, data_nxt;
    logic               par_q, par_nxt;
    logic               sreq_q, sreq_nxt;
    logic [NUM_REQ-1:0] ack_q, ack_nxt;
    logic [NUM_REQ-1:0] done_q, done_nxt;
    logic               txd_q;

`ifdef UART_TX_ARB_LOCK_EN
    localparam int unsigned BURST_W = $clog2(LOCK_MAX + 1);
    logic [BURST_W-1:0] burst_q, burst_nxt;
`endif

    logic [7:0]         data_arr [NUM_REQ];
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = bus.req_data[8*g +: 8];
    end

    // Round-robin search: first requesting index at or above rr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!pick_found && bus.req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic for the grant/transmit cycle.
    always_comb begin
        state_nxt = state_q;
        rr_nxt    = rr_q;
        idx_nxt   = idx_q;
        gv_nxt    = gv_q;
        data_nxt  = data_q;
        par_nxt   = par_q;
        sreq_nxt  = sreq_q;
        ack_nxt   = '0;
        done_nxt  = '0;
`ifdef UART_TX_ARB_LOCK_EN
        burst_nxt = burst_q;
`endif
        case (state_q)
            S_IDLE: begin
                sreq_nxt = 1'b0;
                if (pick_found) begin
                    idx_nxt           = pick_idx;
                    gv_nxt            = 1'b1;
                    data_nxt          = data_arr[pick_idx];
                    par_nxt           = bus.req_parity[pick_idx];
                    ack_nxt[pick_idx] = 1'b1;
                    state_nxt         = S_REQ;
`ifdef UART_TX_ARB_LOCK_EN
                    burst_nxt         = BURST_W'(1);
`endif
                end
            end
            S_REQ: begin
                sreq_nxt = 1'b1;
                // A transmitter that reports done without ever showing busy
                // still completes the byte here.
                if (bus.tx_done) begin
                    done_nxt[idx_q] = 1'b1;
                    sreq_nxt        = 1'b0;
                    state_nxt       = S_RELEASE;
                end else if (bus.tx_busy) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                sreq_nxt = 1'b1;
                if (bus.tx_done && !txd_q) begin
                    done_nxt[idx_q] = 1'b1;
                    sreq_nxt        = 1'b0;
                    state_nxt       = S_RELEASE;
                end
            end
            S_RELEASE: begin
                sreq_nxt = 1'b0;
                if (!bus.tx_busy && !bus.tx_done) begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (lock[idx_q] && bus.req[idx_q] && (burst_q < BURST_W'(LOCK_MAX))) begin
                        data_nxt       = data_arr[idx_q];
                        par_nxt        = bus.req_parity[idx_q];
                        ack_nxt[idx_q] = 1'b1;
                        burst_nxt      = burst_q + BURST_W'(1);
                        state_nxt      = S_REQ;
                    end else begin
                        gv_nxt    = 1'b0;
                        rr_nxt    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        state_nxt = S_IDLE;
                    end
`else
                    gv_nxt    = 1'b0;
                    rr_nxt    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    state_nxt = S_IDLE;
`endif
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset returns everything to idle at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            gv_q    <= 1'b0;
            data_q  <= 8'h00;
            par_q   <= 1'b0;
            sreq_q  <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            txd_q   <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            rr_q    <= rr_nxt;
            idx_q   <= idx_nxt;
            gv_q    <= gv_nxt;
            data_q  <= data_nxt;
            par_q   <= par_nxt;
            sreq_q  <= sreq_nxt;
            ack_q   <= ack_nxt;
            done_q  <= done_nxt;
            txd_q   <= bus.tx_done;
`ifdef UART_TX_ARB_LOCK_EN
            burst_q <= burst_nxt;
`endif
        end
    end

    assign bus.ack           = ack_q;
    assign bus.done          = done_q;
    assign bus.grant_valid   = gv_q;
    assign bus.grant_idx     = idx_q;
    assign bus.send_request  = sreq_q;
    assign bus.tx_data       = data_q;
    assign bus.parity_enable = par_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table for single-byte transactions plus
// hand-written sequences for reset mid-byte and (when built with
// UART_TX_ARB_LOCK_EN) locked bursts.
module tb_uart_tx_arbiter;
    localparam int unsigned NUM_REQ = 4;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef UART_TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0] lock;
`endif

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .LOCK_MAX(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
`ifdef UART_TX_ARB_LOCK_EN
        .lock(lock),
`endif
        .bus(bus.master)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  par;
        bit          stub;
        bit          pulse;
        int unsigned exp_idx;
        logic [7:0]  exp_data;
        logic        exp_par;
    } vec_t;

    vec_t vecs [15];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One byte through the arbiter, with a uart_tx stand-in driven here.
    task automatic serve(input int unsigned idx, input logic [7:0] d, input logic p,
                         input bit stub, input bit pulse, input bit expect_release,
                         input logic [31:0] data_after);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ack != '0) break;
        end
        check("ack", 32'(bus.ack), 32'(onehot));
        check("grant_idx", 32'(bus.grant_idx), 32'(idx));
        check("grant_valid", 32'(bus.grant_valid), 32'd1);
        check("tx_data", 32'(bus.tx_data), 32'(d));
        check("parity_enable", 32'(bus.parity_enable), 32'(p));
        check("sreq_at_ack", 32'(bus.send_request), 32'd0);
        bus.req_data = data_after;
        if (pulse) bus.req = '0;
        @(negedge clk);
        check("sreq_high", 32'(bus.send_request), 32'd1);
        check("ack_once", 32'(bus.ack), 32'd0);
        if (!stub) begin
            bus.tx_busy = 1'b1;
            @(negedge clk);
            check("sreq_held", 32'(bus.send_request), 32'd1);
            check("no_early_done", 32'(bus.done), 32'd0);
            @(negedge clk);
            check("sreq_held2", 32'(bus.send_request), 32'd1);
            bus.tx_busy = 1'b0;
            bus.tx_done = 1'b1;
            @(negedge clk);
            check("done", 32'(bus.done), 32'(onehot));
            check("sreq_low", 32'(bus.send_request), 32'd0);
            check("tx_data_stable", 32'(bus.tx_data), 32'(d));
            check("par_stable", 32'(bus.parity_enable), 32'(p));
            bus.tx_done = 1'b0;
        end else begin
            bus.tx_done = 1'b1;
            @(negedge clk);
            check("stub_done", 32'(bus.done), 32'(onehot));
            check("stub_sreq_low", 32'(bus.send_request), 32'd0);
            @(negedge clk);
            check("stub_done_once", 32'(bus.done), 32'd0);
            check("stub_hold_release", 32'(bus.grant_valid), 32'd1);
            bus.tx_done = 1'b0;
        end
        if (expect_release) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (!bus.grant_valid) break;
            end
            check("release", 32'(bus.grant_valid), 32'd0);
            check("done_after", 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen;
        vec_t v;

        //             req      data           par     stub  pulse idx data   par
        vecs[0]  = '{4'b0001, 32'hD3C2B155, 4'b0001, 1'b0, 1'b0, 0, 8'h55, 1'b1};
        vecs[1]  = '{4'b1111, 32'hD3C2B1A0, 4'b0101, 1'b0, 1'b0, 1, 8'hB1, 1'b0};
        vecs[2]  = '{4'b1111, 32'hD3C2B1A0, 4'b0101, 1'b0, 1'b0, 2, 8'hC2, 1'b1};
        vecs[3]  = '{4'b1111, 32'hD3C2B1A0, 4'b0101, 1'b0, 1'b0, 3, 8'hD3, 1'b0};
        vecs[4]  = '{4'b1111, 32'hD3C2B1A0, 4'b0101, 1'b0, 1'b0, 0, 8'hA0, 1'b1};
        vecs[5]  = '{4'b1111, 32'hD3C2B1A0, 4'b0101, 1'b0, 1'b0, 1, 8'hB1, 1'b0};
        vecs[6]  = '{4'b1111, 32'hD3C2B1A0, 4'b0101, 1'b0, 1'b0, 2, 8'hC2, 1'b1};
        vecs[7]  = '{4'b1111, 32'hD3C2B1A0, 4'b0101, 1'b0, 1'b0, 3, 8'hD3, 1'b0};
        vecs[8]  = '{4'b1001, 32'hD3C2B1A0, 4'b1000, 1'b1, 1'b0, 0, 8'hA0, 1'b0};
        vecs[9]  = '{4'b1001, 32'hD3C2B1A0, 4'b1000, 1'b0, 1'b0, 3, 8'hD3, 1'b1};
        vecs[10] = '{4'b0100, 32'h00770000, 4'b0100, 1'b0, 1'b1, 2, 8'h77, 1'b1};
        vecs[11] = '{4'b0110, 32'hD3C2B1A0, 4'b0000, 1'b0, 1'b0, 1, 8'hB1, 1'b0};
        vecs[12] = '{4'b0011, 32'hD3C2B1A0, 4'b0000, 1'b0, 1'b0, 0, 8'hA0, 1'b0};
        vecs[13] = '{4'b0011, 32'hD3C2B1A0, 4'b0000, 1'b0, 1'b0, 1, 8'hB1, 1'b0};
        vecs[14] = '{4'b1111, 32'hD3C2B1A0, 4'b1111, 1'b1, 1'b0, 2, 8'hC2, 1'b1};

        resetn         = 1'b0;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.req_parity = '0;
        bus.tx_busy    = 1'b0;
        bus.tx_done    = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        lock           = '0;
`endif

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
        check("rst_sreq", 32'(bus.send_request), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_parity", 32'(bus.parity_enable), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_no_grant", 32'(bus.grant_valid), 32'd0);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            bus.req        = v.req;
            bus.req_data   = v.data;
            bus.req_parity = v.par;
            serve(v.exp_idx, v.exp_data, v.exp_par, v.stub, v.pulse, 1'b1, ~v.data);
            if (v.pulse) begin
                seen = '0;
                repeat (3) begin
                    @(negedge clk);
                    seen = seen | bus.ack;
                end
                check("pulse_no_second_ack", 32'(seen), 32'd0);
            end
        end
        bus.req = '0;

        // Reset while BUSY: rr pointer was 3, so a post-reset 4'b1100 must pick 2
        @(negedge clk);
        bus.req        = 4'b0100;
        bus.req_data   = 32'hD3C2B1A0;
        bus.req_parity = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ack != '0) break;
        end
        check("rstseq_ack", 32'(bus.ack), 32'b0100);
        @(negedge clk);
        bus.tx_busy = 1'b1;
        @(negedge clk);
        check("rstseq_sreq_busy", 32'(bus.send_request), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("rstseq_sreq", 32'(bus.send_request), 32'd0);
        check("rstseq_gv", 32'(bus.grant_valid), 32'd0);
        check("rstseq_tx_data", 32'(bus.tx_data), 32'd0);
        check("rstseq_grant_idx", 32'(bus.grant_idx), 32'd0);
        bus.tx_busy = 1'b0;
        bus.req     = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rstseq_idle", 32'(bus.grant_valid), 32'd0);
        bus.req        = 4'b1100;
        bus.req_parity = 4'b0000;
        serve(2, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000);
        bus.req = '0;

`ifdef UART_TX_ARB_LOCK_EN
        // Locked burst: rr pointer is 3, so 0 first, then 16 bytes from 1, then 0
        @(negedge clk);
        lock           = 4'b0010;
        bus.req        = 4'b0011;
        bus.req_data   = 32'hD3C2B1A0;
        bus.req_parity = 4'b0010;
        serve(0, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD3C2B1A0);
        for (int n = 1; n <= 16; n++) begin
            serve(1, 8'hB1, 1'b1, 1'b0, 1'b0, (n == 16), 32'hD3C2B1A0);
        end
        serve(0, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD3C2B1A0);
        bus.req = '0;
        lock    = '0;
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
